alpha_gain_mixer: RTL
=====================

// Module: alpha_gain_mixer
// PURPOSE
// - Downstream consumer of the alpha (gain-select) flag from the HDR alpha block.
// - Selects, per valid sample, the high-gain (HG) or low-gain (LG) channel sample.
// - Rescales LG samples to the HG scale and emits one merged wide HDR sample stream.
// - Switching policy:
//   - HG->LG is immediate, to protect against overload.
//   - LG->HG is debounced over HOLD_SAMPLES consecutive valid samples.
// PARAMETERS
// - GAIN_SHIFT    3  log2 of the HG/LG gain ratio; LG sample is left-shifted by this.
// - HOLD_SAMPLES  4  consecutive valid alpha=0 samples required before LG->HG (>=1).
// - OUT_W         9+GAIN_SHIFT  output sample width (derived, not overridable).
// PORTS
// - clk           in   1      single clock, all logic rising-edge.
// - reset         in   1      synchronous, active-high reset.
// - sample_valid  in   1      hg_sample/lg_sample/alpha qualified this cycle.
// - hg_sample     in   9      signed two's-complement high-gain sample.
// - lg_sample     in   9      signed two's-complement low-gain sample.
// - alpha         in   1      1 = large signal, use LG; 0 = small signal, HG requested.
// - out_valid     out  1      out_sample valid; one cycle after sample_valid.
// - out_sample    out  OUT_W  signed merged sample.
// - gain_sel      out  1      path used for out_sample: 1 = LG, 0 = HG.
// - switch_pulse  out  1      one-cycle pulse with out_valid when gain_sel differs from previous.
// BEHAVIOUR
// - Reset values: state=S_LG, hold_cnt=0, out_valid=0, out_sample=0, gain_sel=1, switch_pulse=0.
//   - Starting in LG matches alpha=1 out of reset.
// - FSM states: S_LG, S_ARM, S_HG. Transitions are evaluated only when sample_valid=1.
//   - S_LG, alpha=1: stay in S_LG, hold_cnt=0.
//   - S_LG, alpha=0: if HOLD_SAMPLES==1 go to S_HG; else go to S_ARM with hold_cnt=1.
//   - S_ARM, alpha=1: go to S_LG, hold_cnt=0. Debounce restarts from zero.
//   - S_ARM, alpha=0: if hold_cnt+1==HOLD_SAMPLES go to S_HG with hold_cnt=0; else hold_cnt+1.
//   - S_HG, alpha=1: go to S_LG immediately.
//   - S_HG, alpha=0: stay in S_HG.
// - Path for a sample is the NEXT state's path. S_LG and S_ARM use LG; S_HG uses HG.
//   - The sample that asserts alpha=1 is already output via LG.
//   - The sample that completes the hold is already output via HG.
// - sample_valid=0 cycles:
//   - FSM and hold_cnt hold their values; alpha is ignored.
//   - out_valid=0; out_sample and gain_sel hold their last values.
// - Arithmetic:
//   - HG path: out_sample = sign-extend(hg_sample) to OUT_W.
//   - LG path: out_sample = sign-extend(lg_sample) << GAIN_SHIFT.
//   - Exact in OUT_W bits, so no saturation is needed.
//   - -256 on LG gives -256*2^GAIN_SHIFT.
// - Latency: exactly 1 cycle, sample_valid -> out_valid. Throughput: 1 sample/cycle.
// - switch_pulse=1 only on a valid output whose gain_sel differs from the previous valid
//   output's gain_sel. The first output after reset is compared against gain_sel=1.
// - hold_cnt width: $clog2(HOLD_SAMPLES+1). It never exceeds HOLD_SAMPLES-1.
// - Reset mid-operation: next cycle all registers take reset values. An in-flight sample is dropped.
// - reset has priority over sample_valid in the same cycle.
// TESTING
// (All cases use GAIN_SHIFT=3, HOLD_SAMPLES=4 unless noted.)
// - Reset + sample (lg=10, hg=80, alpha=1), no switch:
//   - out_valid 1 cycle later; out_sample=80; gain_sel=1; switch_pulse=0.
// - Debounce to HG: 4 valid samples with alpha=0, hg=5:
//   - Outputs 1-3 via LG; output 4: out_sample=5, gain_sel=0, switch_pulse=1.
// - Debounce abort: alpha=0,0,0,1,0,0,0,0:
//   - gain_sel stays 1 through sample 7; flips to 0 on sample 8 with switch_pulse.
// - Immediate HG->LG from S_HG: alpha=1 with lg=-256:
//   - Same sample: out_sample=-2048, gain_sel=1, switch_pulse=1.
// - Gaps: sample_valid toggled 1,0,0,1 with alpha=0:
//   - hold_cnt advances only on valid cycles; out_valid mirrors valid delayed by 1.
// - HOLD_SAMPLES=1 build; reset asserted while in S_HG:
//   - First alpha=0 sample switches to HG.
//   - Reset returns to gain_sel=1, out_valid=0 on the next cycle.

Source files
------------

// File: rtl/alpha_gain_mixer.sv
// alpha_gain_mixer
//   Merges a high-gain (HG) and a low-gain (LG) 9-bit signed sample stream
//   into one wide HDR stream.
//   - LG samples are rescaled to the HG scale by a left shift of GAIN_SHIFT.
//   - The alpha flag selects the path for each sample.
//   - Switching policy:
//       HG->LG happens immediately, to protect against overload.
//       LG->HG happens only after HOLD_SAMPLES consecutive valid alpha=0 samples.
//
// Parameters
//   GAIN_SHIFT    log2 of the HG/LG gain ratio.
//   HOLD_SAMPLES  debounce length for LG->HG; must be >= 1.
//   OUT_W         derived output width, 9 + GAIN_SHIFT.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   sample_valid  qualifies hg_sample, lg_sample and alpha
//   hg_sample     signed high-gain sample
//   lg_sample     signed low-gain sample
//   alpha         1 = large signal (use LG), 0 = small signal (HG requested)
//   out_valid     out_sample is valid; sample_valid delayed by one cycle
//   out_sample    signed merged sample, OUT_W bits
//   gain_sel      path used for out_sample: 1 = LG, 0 = HG
//   switch_pulse  one-cycle flag on a valid output whose gain_sel changed
module alpha_gain_mixer #(
  parameter  int GAIN_SHIFT   = 3,
  parameter  int HOLD_SAMPLES = 4,
  localparam int OUT_W        = 9 + GAIN_SHIFT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic signed [8:0]       hg_sample,
  input  logic signed [8:0]       lg_sample,
  input  logic                    alpha,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_sample,
  output logic                    gain_sel,
  output logic                    switch_pulse
);

  localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);

  typedef enum logic [1:0] {
    S_LG  = 2'd0,
    S_ARM = 2'd1,
    S_HG  = 2'd2
  } state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          hold_cnt, cnt_nxt, cnt_inc;
  logic                      path_lg;
  logic signed [OUT_W-1:0]   hg_ext, lg_ext, mixed;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs at the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_LG;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic; only valid samples move the FSM
  // ---------------------------------------------------------------------------
  assign cnt_inc = hold_cnt + CNT_W'(1);

  // NOTE: defaults at the top of the block give every path an assignment,
  // so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = hold_cnt;
    if (sample_valid) begin
      unique case (state)
        S_LG: begin
          if (alpha) begin
            cnt_nxt = '0;
          end else if (HOLD_SAMPLES == 1) begin
            state_nxt = S_HG;
            cnt_nxt   = '0;
          end else begin
            state_nxt = S_ARM;
            cnt_nxt   = CNT_W'(1);
          end
        end
        S_ARM: begin
          if (alpha) begin
            // A single large sample restarts the debounce from zero.
            state_nxt = S_LG;
            cnt_nxt   = '0;
          end else if (cnt_inc == CNT_W'(HOLD_SAMPLES)) begin
            state_nxt = S_HG;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        S_HG: begin
          if (alpha) state_nxt = S_LG;
        end
        default: begin
          state_nxt = S_LG;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output datapath; the path follows the state the sample moves the FSM into,
  // so the overload sample itself already goes out via LG.
  // ---------------------------------------------------------------------------
  always_comb begin
    path_lg = (state_nxt != S_HG);
    hg_ext  = OUT_W'(hg_sample);
    // The shift is exact in OUT_W bits, so no saturation is required.
    lg_ext  = OUT_W'(lg_sample) <<< GAIN_SHIFT;
    mixed   = path_lg ? lg_ext : hg_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_sample   <= '0;
      gain_sel     <= 1'b1;
      switch_pulse <= 1'b0;
    end else begin
      out_valid <= sample_valid;
      if (sample_valid) begin
        out_sample   <= mixed;
        gain_sel     <= path_lg;
        // gain_sel still holds the previous valid output's path here.
        switch_pulse <= (path_lg != gain_sel);
      end else begin
        switch_pulse <= 1'b0;
      end
    end
  end

endmodule
